// File: rtl/id_hazard_sched.sv
// Decode-stage hazard scheduler: EX/MEM scoreboard, operand forwarding selects,
// load-use stall, debug halt/step sequencer and a saturating stall counter.
module id_hazard_sched #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [4:0]       id_dest,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic [1:0]       fwa,
  output logic [1:0]       fwb,
  output logic             wpcir,
  output logic             bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;

  state_t     state, state_nx;
  logic       ex_v, ex_wreg, ex_m2reg;
  logic [4:0] ex_dest;
  logic       mem_v, mem_wreg, mem_m2reg;
  logic [4:0] mem_dest;

  logic use_rs, use_rt;
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic luh;

  assign use_rs = id_valid & id_use_rs;
  assign use_rt = id_valid & id_use_rt;

  // r0 is hardwired zero, so it never matches a producer
  assign ex_hit_rs  = ex_v  & ex_wreg  & (ex_dest  == id_rs) & (id_rs != 5'd0);
  assign ex_hit_rt  = ex_v  & ex_wreg  & (ex_dest  == id_rt) & (id_rt != 5'd0);
  assign mem_hit_rs = mem_v & mem_wreg & (mem_dest == id_rs) & (id_rs != 5'd0);
  assign mem_hit_rt = mem_v & mem_wreg & (mem_dest == id_rt) & (id_rt != 5'd0);

  assign luh = (use_rs & ex_hit_rs & ex_m2reg) | (use_rt & ex_hit_rt & ex_m2reg);

  always_comb begin
    fwa = 2'b00;
    if (use_rs) begin
      if (ex_hit_rs) begin
        fwa = ex_m2reg ? 2'b00 : 2'b01;
      end else if (mem_hit_rs) begin
        fwa = mem_m2reg ? 2'b11 : 2'b10;
      end
    end
  end

  always_comb begin
    fwb = 2'b00;
    if (use_rt) begin
      if (ex_hit_rt) begin
        fwb = ex_m2reg ? 2'b00 : 2'b01;
      end else if (mem_hit_rt) begin
        fwb = mem_m2reg ? 2'b11 : 2'b10;
      end
    end
  end

  assign wpcir  = (state != S_HALT) & ~luh;
  assign bubble = ~wpcir;
  assign halted = (state == S_HALT);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN:   if (dbg_halt) state_nx = S_HALT;
      S_HALT: begin
        if (dbg_step)       state_nx = S_STEP;
        else if (!dbg_halt) state_nx = S_RUN;
      end
      S_STEP:  if (!luh) state_nx = S_HALT;
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nx;
    end
  end

  // While halted bubble is high, so EX refills with invalid and the MEM slot follows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v      <= 1'b0;
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_dest   <= '0;
      mem_v     <= 1'b0;
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
      mem_dest  <= '0;
    end else begin
      mem_v     <= ex_v;
      mem_wreg  <= ex_wreg;
      mem_m2reg <= ex_m2reg;
      mem_dest  <= ex_dest;
      ex_v      <= id_valid & ~bubble;
      ex_wreg   <= id_wreg;
      ex_m2reg  <= id_m2reg;
      ex_dest   <= id_dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (luh && (state != S_HALT) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_sched.sv
// Bench for id_hazard_sched: directed scenarios plus random traffic, all checked
// against an in-bench model of in-flight writers and the debug mode.
module tb_id_hazard_sched;

  localparam int unsigned CW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg;
  logic [4:0]    id_rs, id_rt, id_dest;
  logic          dbg_halt, dbg_step;
  logic [1:0]    fwa, fwb;
  logic          wpcir, bubble, halted;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  id_hazard_sched #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_dest(id_dest),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step),
    .fwa(fwa), .fwb(fwb), .wpcir(wpcir), .bubble(bubble),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: pipe[0] is the instruction one ahead of ID, pipe[1] two ahead.
  typedef struct {bit v; bit wr; bit ld; int dest;} ent_t;
  ent_t pipe[2];
  int   mode;   // 0 running, 1 halted, 2 stepping
  int   cnt;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) pipe[i] = '{v: 0, wr: 0, ld: 0, dest: 0};
    mode = 0;
    cnt  = 0;
  endfunction

  // Operand source for register r; sets stall when the producer one ahead is a load
  function automatic int src_sel(input int r, input bit used, output bit stall);
    stall = 0;
    if (!used || r == 0) return 0;
    for (int d = 0; d < 2; d++) begin
      if (pipe[d].v && pipe[d].wr && pipe[d].dest == r) begin
        if (d == 0) begin
          if (pipe[d].ld) begin
            stall = 1;
            return 0;
          end
          return 1;
        end
        return pipe[d].ld ? 3 : 2;
      end
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive ID/debug inputs after the falling edge, check, then advance the model
  task automatic cyc(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                     input bit wr, input bit ld, input int dst, input bit h, input bit s);
    int ea, eb;
    bit sa, sb, luh, wp;
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
    id_use_rs = urs; id_use_rt = urt; id_wreg = wr; id_m2reg = ld;
    id_dest = 5'(dst); dbg_halt = h; dbg_step = s;
    #1;
    ea  = src_sel(rs, v && urs, sa);
    eb  = src_sel(rt, v && urt, sb);
    luh = sa || sb;
    wp  = (mode != 1) && !luh;
    if (!sa) chk("fwa", int'(fwa), ea);
    if (!sb) chk("fwb", int'(fwb), eb);
    chk("wpcir", int'(wpcir), int'(wp));
    chk("bubble", int'(bubble), int'(!wp));
    chk("halted", int'(halted), int'(mode == 1));
    chk("stall_cnt", int'(stall_cnt), cnt);
    @(posedge clk);
    if (luh && mode != 1 && cnt < SAT) cnt++;
    pipe[1] = pipe[0];
    if (wp && v) pipe[0] = '{v: 1, wr: wr, ld: ld, dest: dst};
    else         pipe[0] = '{v: 0, wr: 0, ld: 0, dest: 0};
    case (mode)
      0: if (h) mode = 1;
      1: if (s) mode = 2; else if (!h) mode = 0;
      default: if (!luh) mode = 1;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input bit h);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, h, 0);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_m2reg = 0; id_dest = '0; dbg_halt = 0; dbg_step = 0;
    model_reset();
    #2;
    chk("rst_fwa", int'(fwa), 0);
    chk("rst_wpcir", int'(wpcir), 1);
    chk("rst_halted", int'(halted), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // ALU -> ALU: 01 then 10
    cyc(1, 1, 2, 1, 1, 1, 0, 3, 0, 0);
    cyc(1, 3, 4, 1, 1, 1, 0, 6, 0, 0);
    chk("alu_fwd_mem_pre", int'(wpcir), 1);
    cyc(1, 3, 0, 1, 0, 1, 0, 8, 0, 0);

    // Load-use: one stall, then 11
    cyc(1, 1, 0, 1, 0, 1, 1, 5, 0, 0);
    cyc(1, 2, 5, 1, 1, 1, 0, 9, 0, 0);
    cyc(1, 2, 5, 1, 1, 1, 0, 9, 0, 0);
    chk("lu_cnt", int'(stall_cnt), 1);

    // r0 load, and unused operands after a load
    cyc(1, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 1, 0, 4, 0, 0);
    cyc(1, 1, 0, 1, 0, 1, 1, 7, 0, 0);
    cyc(1, 7, 7, 0, 0, 0, 0, 0, 0, 0);

    // Halt, drain, single step, resume
    cyc(1, 1, 0, 1, 0, 1, 0, 10, 1, 0);
    cyc(1, 10, 0, 1, 0, 1, 0, 11, 1, 0);
    cyc(1, 10, 0, 1, 0, 1, 0, 11, 1, 0);
    cyc(1, 10, 0, 1, 0, 1, 0, 11, 1, 1);
    cyc(1, 11, 0, 1, 0, 1, 0, 12, 1, 0);
    cyc(1, 11, 0, 1, 0, 1, 0, 12, 1, 0);
    cyc(1, 11, 0, 1, 0, 1, 0, 12, 0, 0);
    idle(0);

    // Halt coinciding with a load-use stall; step and release together
    cyc(1, 1, 0, 1, 0, 1, 1, 13, 0, 0);
    cyc(1, 13, 0, 1, 0, 1, 0, 14, 1, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0);
    idle(0);

    // Saturation: five load-use stalls on a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 0, 1, 0, 1, 1, 5, 0, 0);
      cyc(1, 5, 5, 1, 1, 1, 0, 9, 0, 0);
      cyc(1, 5, 5, 1, 1, 1, 0, 9, 0, 0);
    end
    chk("sat_cnt", int'(stall_cnt), SAT);

    // Async reset in the middle of a stall
    cyc(1, 1, 0, 1, 0, 1, 1, 6, 0, 0);
    id_valid = 1; id_rs = 5'd6; id_rt = 5'd6; id_use_rs = 1; id_use_rt = 1;
    #1;
    chk("pre_rst_wpcir", int'(wpcir), 0);
    rst = 1'b1;
    #1;
    chk("arst_cnt", int'(stall_cnt), 0);
    chk("arst_wpcir", int'(wpcir), 1);
    chk("arst_bubble", int'(bubble), 0);
    chk("arst_fwa", int'(fwa), 0);
    chk("arst_fwb", int'(fwb), 0);
    chk("arst_halted", int'(halted), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic over a small register set to provoke hazards
    begin
      bit h = 0;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 15) == 0) h = !h;
        cyc(bit'($urandom_range(0, 4) != 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), h, bit'($urandom_range(0, 3) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_hazard_sched.md
# id_hazard_sched

Pipeline hazard scheduler for the decode stage of the 5-stage MIPS pipeline. It keeps a two-entry scoreboard of the instructions in EX and MEM and compares it against the source registers of the instruction in ID. From that it drives the operand-forwarding selects, the PC/IF-ID write enable (`wpcir`) and the EX bubble request. It also adds a debug halt/single-step sequencer and a saturating load-use stall counter.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `id_valid`  input  1  ID holds a real instruction; 0 means a bubble.
- `id_rs`, `id_rt`  input  5 each  source register numbers of the ID instruction.
- `id_use_rs`, `id_use_rt`  input  1 each  ID instruction actually reads `rs` / `rt`.
- `id_wreg`  input  1  ID instruction writes a register.
- `id_m2reg`  input  1  ID instruction is a load.
- `id_dest`  input  5  ID destination register (already rt/rd/31-selected).
- `dbg_halt`  input  1  level; request pipeline halt.
- `dbg_step`  input  1  pulse; advance exactly one instruction while halted.
- `fwa`, `fwb`  output  2 each  operand source select: 00 regfile, 01 ex_aluR, 10 mem_aluR, 11 mem_mdata.
- `wpcir`  output  1  1 = PC and IF/ID advance; 0 = hold.
- `bubble`  output  1  1 = EX receives a NOP instead of the ID instruction.
- `halted`  output  1  sequencer is in HALT.
- `stall_cnt`  output  `CNT_W`  number of load-use stall cycles, saturating.

## Operation
**Scoreboard.** Two registered entries, EX and MEM. Each entry holds `{v, wreg, m2reg, dest}`.
- At every clock edge: MEM ← EX. EX ← ID fields when `bubble`=0 and `id_valid`=1; otherwise EX ← invalid.
- An entry "matches" source register r when all of these hold: `v`, `wreg`, `dest`==r, r≠0.
- The WB stage is not tracked. The regfile is write-first, so WB results are visible to ID reads in the same cycle.

**Forwarding.** Computed separately for `fwa` (`rs`) and `fwb` (`rt`). Only applies when the corresponding `id_use_*`=1 and `id_valid`=1; otherwise the select is 00. First match wins:
- EX matches and EX is not a load → 01.
- EX matches and EX is a load → load-use hazard; the select value is don't-care.
- MEM matches and MEM is a load → 11.
- MEM matches and MEM is not a load → 10.
- No match → 00.

**Load-use hazard** (`luh`). Asserted when either used source has an EX-entry match that is a load.

**Debug sequencer states.**
- RUN → HALT: when `dbg_halt`=1.
- HALT → STEP: when `dbg_step`=1.
- HALT → RUN: when `dbg_halt`=0.
- STEP → HALT: unconditionally after one cycle, unless that cycle had `luh`=1, in which case it stays in STEP.
- `dbg_step` in RUN is ignored.
- `halted` = (state==HALT).

**Outputs.**
- `wpcir` = (state≠HALT) & ~`luh`.
- `bubble` = ~`wpcir`.
- In HALT the scoreboard drains: both entries become invalid within 2 cycles.

**Stall counter.** `stall_cnt` increments on each cycle where `luh`=1 and state≠HALT. It saturates at 2^`CNT_W`−1.

## Timing
- `fwa`, `fwb`, `wpcir` and `bubble` are combinational from the registered scoreboard/state and the current ID inputs: zero-cycle latency, valid in the same cycle.
- A load immediately followed by a consumer stalls exactly 1 cycle; the next cycle forwards with select 11.
- Reset is asynchronous. It forces the state to RUN, both entries invalid and `stall_cnt`=0. Output values during and after reset: `fwa`=`fwb`=00, `wpcir`=1, `bubble`=0, `halted`=0.
- Reset in the middle of a stall or a step aborts it immediately.
- `dbg_halt` and `luh` in the same cycle: HALT takes effect at the next edge, and that cycle is counted as a stall.
- `dbg_step` and `dbg_halt` deassertion in the same HALT cycle: the step takes priority (→ STEP), and the machine then returns to HALT.
- Register 0 never matches, so writes to r0 never cause forwarding or a stall.

## Test plan
- **ALU→ALU dependency.** Issue `add $3` then `sub` using `$3` as rs, back-to-back → second instruction sees `fwa`=01, `wpcir`=1. One cycle later a third instruction using `$3` sees `fwa`=10.
- **Load-use.** Issue `lw $5` then `add` using `$5` as rt → one cycle with `wpcir`=0, `bubble`=1 and `stall_cnt` 0→1. The next cycle shows `fwb`=11, `wpcir`=1.
- **r0 and unused operands.** Issue `lw $0`, then a consumer of `$0` → no stall, selects 00. Issue `lw $7` followed by `j` with `id_use_rs`=`id_use_rt`=0 → no stall.
- **Halt/step.** Assert `dbg_halt` → `halted`=1, `wpcir`=0 and the scoreboard is empty after 2 cycles. Pulse `dbg_step` → exactly one cycle with `wpcir`=1, then `halted`=1 again. Deassert `dbg_halt` → RUN.
- **Saturation and async reset.** With `CNT_W`=2, drive 5 load-use stalls → `stall_cnt`=3. Assert `rst` asynchronously mid-stall → `stall_cnt`=0, `wpcir`=1, `fwa`=`fwb`=00, `halted`=0 immediately, with no clock edge needed.
